// File: rtl/usb_ep_echo_if.sv
// Endpoint handshake bundle between the echo block (master) and the USB function core (slave).
interface usb_ep_echo_if;
  logic [7:0] ep2_dout;
  logic       ep2_re;
  logic       ep2_empty;
  logic [7:0] ep1_din;
  logic       ep1_we;
  logic       ep1_full;

  modport master (
    input  ep2_dout,
    input  ep2_empty,
    input  ep1_full,
    output ep2_re,
    output ep1_din,
    output ep1_we
  );

  modport slave (
    output ep2_dout,
    output ep2_empty,
    output ep1_full,
    input  ep2_re,
    input  ep1_din,
    input  ep1_we
  );
endinterface

// File: rtl/usb_ep_echo.sv
// Echoes bytes read from the OUT endpoint (EP2) to the IN endpoint (EP1) through a small
// circular FIFO, XORing each byte with XOR_MASK. DEPTH must be a power of two, 2..64.
module usb_ep_echo #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [7:0]  XOR_MASK = 8'h00
) (
  input  logic          clk_i,
  input  logic          rst_i,
  usb_ep_echo_if.master ep,
  output logic [7:0]    led_o,
  output logic [15:0]   byte_cnt_o,
  output logic [6:0]    buf_cnt_o
);

  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [6:0]  DEPTH_CNT = 7'(DEPTH);

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_CAP  = 1'b1;
  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_GAP  = 1'b1;

  logic [0:0]    r_state_q, r_state_d;
  logic [0:0]    w_state_q, w_state_d;
  logic          ep2_re_q, ep2_re_d;
  logic          ep1_we_q, ep1_we_d;
  logic [7:0]    ep1_din_q, ep1_din_d;
  logic [7:0]    led_q, led_d;
  logic [15:0]   byte_cnt_q, byte_cnt_d;
  logic [6:0]    buf_cnt_q, buf_cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [DEPTH];
  logic          push;
  logic          pop;
  logic [7:0]    head;

  // The strobe cycle stays in R_IDLE with ep2_re high; R_CAP is the cycle the core presents data.
  always_comb begin
    r_state_d = r_state_q;
    ep2_re_d  = 1'b0;
    push      = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (ep2_re_q) begin
          r_state_d = R_CAP;
        end else if (!ep.ep2_empty && (buf_cnt_q < DEPTH_CNT)) begin
          ep2_re_d = 1'b1;
        end
      end
      R_CAP: begin
        push      = 1'b1;
        r_state_d = R_IDLE;
      end
    endcase
  end

  // An empty buffer forwards the byte being captured so a lone byte reaches EP1 two cycles after ep2_re.
  always_comb begin
    w_state_d = w_state_q;
    ep1_we_d  = 1'b0;
    ep1_din_d = ep1_din_q;
    pop       = 1'b0;
    head      = (buf_cnt_q == 7'd0) ? ep.ep2_dout : mem_q[rd_ptr_q];
    case (w_state_q)
      W_IDLE: begin
        if (ep1_we_q) begin
          w_state_d = W_GAP;
        end else if (((buf_cnt_q != 7'd0) || push) && !ep.ep1_full) begin
          ep1_we_d  = 1'b1;
          ep1_din_d = head ^ XOR_MASK;
          pop       = 1'b1;
        end
      end
      W_GAP: begin
        w_state_d = W_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    buf_cnt_d  = buf_cnt_q + 7'(push) - 7'(pop);
    byte_cnt_d = ep1_we_q ? byte_cnt_q + 16'd1 : byte_cnt_q;
    led_d      = ep1_we_q ? ep1_din_q : led_q;
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= ep.ep2_dout;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state_q  <= R_IDLE;
      w_state_q  <= W_IDLE;
      ep2_re_q   <= 1'b0;
      ep1_we_q   <= 1'b0;
      ep1_din_q  <= 8'h00;
      led_q      <= 8'h00;
      byte_cnt_q <= 16'h0000;
      buf_cnt_q  <= 7'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      r_state_q  <= r_state_d;
      w_state_q  <= w_state_d;
      ep2_re_q   <= ep2_re_d;
      ep1_we_q   <= ep1_we_d;
      ep1_din_q  <= ep1_din_d;
      led_q      <= led_d;
      byte_cnt_q <= byte_cnt_d;
      buf_cnt_q  <= buf_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  assign ep.ep2_re  = ep2_re_q;
  assign ep.ep1_we  = ep1_we_q;
  assign ep.ep1_din = ep1_din_q;
  assign led_o      = led_q;
  assign byte_cnt_o = byte_cnt_q;
  assign buf_cnt_o  = buf_cnt_q;

endmodule

// File: doc/usb_ep_echo.md
USB_EP_ECHO -- requirements
Module: usb_ep_echo

Interface
REQ-001 Parameter DEPTH, default 8, sets the internal byte buffer depth; it SHALL be a power of two from 2 to 64.
REQ-002 Parameter XOR_MASK, default 8'h00, SHALL be XORed onto every byte written to EP1.
REQ-003 clk_i  in  1  single clock for all logic.
REQ-004 rst_i  in  1  reset; one clock; reset is synchronous and active-low.
REQ-005 ep2_dout  in  8  OUT-endpoint read data from the USB function core, valid the cycle after ep2_re.
REQ-006 ep2_re  out  1  one-cycle OUT-endpoint read strobe.
REQ-007 ep2_empty  in  1  OUT endpoint holds no data when 1.
REQ-008 ep1_din  out  8  IN-endpoint write data.
REQ-009 ep1_we  out  1  one-cycle IN-endpoint write strobe.
REQ-010 ep1_full  in  1  IN endpoint cannot accept data when 1.
REQ-011 led_o  out  8  last byte written to EP1.
REQ-012 byte_cnt_o  out  16  total bytes written to EP1.
REQ-013 buf_cnt_o  out  7  current internal buffer occupancy, 0..DEPTH.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 Read FSM states: R_IDLE and R_CAP.
REQ-016 In R_IDLE, when ep2_empty==0 and buf_cnt_o<DEPTH, the block SHALL assert ep2_re for one cycle and go to R_CAP.
REQ-017 In R_CAP, the block SHALL push ep2_dout into the buffer tail and return to R_IDLE, with ep2_re held low.
REQ-018 A new read SHALL be issued at most every 2 cycles.
REQ-019 A read SHALL never be issued when the buffer is full, counting the byte being captured in R_CAP.
REQ-020 Write FSM states: W_IDLE and W_GAP.
REQ-021 In W_IDLE, when buf_cnt_o>0 and ep1_full==0, the block SHALL assert ep1_we for one cycle, drive ep1_din = head ^ XOR_MASK, pop the head, and go to W_GAP.
REQ-022 W_GAP SHALL last exactly one cycle with ep1_we low, then return to W_IDLE; this gives the core one cycle to update ep1_full.
REQ-023 ep1_din SHALL hold its last value while ep1_we is low.
REQ-024 The buffer SHALL be a circular FIFO with read and write pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-025 On a push and pop in the same cycle, buf_cnt_o SHALL be unchanged and the byte order SHALL be preserved.
REQ-026 Bytes SHALL leave EP1 in the exact order they were read from EP2, with none lost or duplicated.
REQ-027 byte_cnt_o SHALL increment by 1 in the cycle after each ep1_we and wrap from 16'hFFFF to 16'h0000.
REQ-028 led_o SHALL update to the written byte (post-XOR) together with byte_cnt_o.
REQ-029 If ep1_full rises while the buffer is non-empty, writes SHALL stall; reads SHALL continue until the buffer is full, then stall.
REQ-030 ep2_empty SHALL be sampled only in R_IDLE; a change while in R_CAP SHALL not cancel the capture.

Reset
REQ-031 While rst_i==0 at a clock edge, both FSMs SHALL go to their IDLE states.
REQ-032 Reset SHALL clear both pointers and buf_cnt_o.
REQ-033 Reset SHALL force ep2_re=0, ep1_we=0, ep1_din=8'h00, led_o=8'h00 and byte_cnt_o=16'h0000.
REQ-034 A reset during R_CAP SHALL discard the byte in flight.
REQ-035 A reset during W_GAP SHALL leave no further strobe.
REQ-036 No strobe SHALL be asserted in the first cycle after rst_i returns to 1.

Verification
REQ-037 Single byte: EP2 supplies 8'hA5, ep1_full=0, XOR_MASK=0 -> ep2_re pulse at t, ep1_we pulse with ep1_din=8'hA5 at t+2, then led_o=8'hA5 and byte_cnt_o=1.
REQ-038 Stream plus mask: EP2 supplies 0x00..0x0F, XOR_MASK=8'hFF -> EP1 receives 0xFF..0xF0 in order, ep1_we pulses at least 2 cycles apart, byte_cnt_o=16.
REQ-039 Backpressure: ep1_full=1 and 12 bytes pending, DEPTH=8 -> exactly 8 ep2_re pulses, buf_cnt_o=8, no ep1_we; after ep1_full=0, all 12 bytes arrive in order.
REQ-040 Pointer wrap: 20 bytes streamed through with ep1_full toggling every 3 cycles -> no loss, no duplicates, order preserved across wrap.
REQ-041 Counter wrap: preload 65535 writes (or force byte_cnt_o=16'hFFFF), then one more byte -> byte_cnt_o=16'h0000.
REQ-042 Mid-op reset: rst_i=0 in the R_CAP cycle with buf_cnt_o=3 -> next cycle all outputs at reset values, and the in-flight byte never appears on EP1.
